// File: rtl/pixel_write_sink.sv
// pixel_write_sink: buffers pixel writes, maps (x,y) to frame-buffer addresses and clears the screen
// Ports:
//   clk, reset_n         clock (posedge) and asynchronous active-low reset
//   x, y, colour         incoming pixel, taken when write_en && ready
//   write_en, ready      pixel handshake; ready only in normal running with FIFO space
//   clear_req            one-cycle pulse starting a full-screen clear
//   mem_addr, mem_data   frame-buffer write address (y*SCREEN_W + x) and colour
//   mem_we, mem_ready    memory handshake; a write completes when both are high
//   busy                 clearing, or any pixel still queued or being written
//   oob_count            saturating count of discarded off-screen pixels
module pixel_write_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        write_en,
    output logic        ready,
    input  logic        clear_req,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        busy,
    output logic [7:0]  oob_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN = 1'b1;

    logic [0:0]  state;
    logic        clear_pend;
    logic [17:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0] fifo_count;
    logic        fifo_full;
    logic        in_range;
    logic [14:0] pix_addr;
    logic        accept;
    logic        clear_hit;
    logic        push;
    logic        pop;
    logic        mem_done;

    // constant multiply reduces to (y<<7)+(y<<5) for a 160-wide screen; max 19199 fits 15 bits
    assign pix_addr   = 15'(y) * 15'(SCREEN_W) + 15'(x);
    assign in_range   = (32'(x) < 32'(SCREEN_W)) && (32'(y) < 32'(SCREEN_H));
    assign fifo_full  = fifo_count == (PW+1)'(FIFO_DEPTH);
    // clear_pend drops ready from the edge after clear_req while a held write drains
    assign ready      = (state == S_RUN) && !clear_pend && !fifo_full;
    assign accept     = write_en && ready;
    assign clear_hit  = (state == S_RUN) && (clear_req || clear_pend);
    assign push       = accept && in_range && !clear_hit;
    assign mem_done   = mem_we && mem_ready;
    assign pop        = (state == S_RUN) && !clear_hit && (fifo_count != '0) && (!mem_we || mem_done);
    assign busy       = (state == S_CLEAR) || (fifo_count != '0) || mem_we;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {pix_addr, colour};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (state == S_CLEAR || clear_hit) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_count <= fifo_count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) oob_count <= '0;
        else if (accept && !in_range && oob_count != 8'hff) oob_count <= oob_count + 8'd1;
    end

    // mem_addr doubles as the sweep counter while clearing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_CLEAR;
            clear_pend <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
        end else if (state == S_CLEAR) begin
            if (clear_req || !mem_we) begin
                mem_we   <= 1'b1;
                mem_addr <= '0;
                mem_data <= CLEAR_COLOUR;
            end else if (mem_ready) begin
                if (mem_addr == LAST_ADDR) begin
                    state  <= S_RUN;
                    mem_we <= 1'b0;
                end else begin
                    mem_addr <= mem_addr + 15'd1;
                end
            end
        end else if (clear_hit) begin
            if (!mem_we || mem_ready) begin
                state      <= S_CLEAR;
                clear_pend <= 1'b0;
                mem_we     <= 1'b1;
                mem_addr   <= '0;
                mem_data   <= CLEAR_COLOUR;
            end else begin
                clear_pend <= 1'b1;
            end
        end else if (pop) begin
            mem_we                <= 1'b1;
            {mem_addr, mem_data}  <= fifo_mem[rd_ptr];
        end else if (mem_done) begin
            mem_we <= 1'b0;
        end
    end
endmodule
